// File: rtl/fmul_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fmul_rr_scheduler
//   Round-robin scheduler that lets N requesters share one pipelined 12-bit
//   fmul core (exc[11:10], sign[9], exp[8:5] bias 7, frac[4:0]). At most one
//   operand pair is issued per cycle. Every result comes back tagged with the
//   ID of the requester that issued it. The data path only routes operands
//   and results; it does no arithmetic on them.
//
// Parameters
//   N         number of requesters (2..8)
//   IDW       requester ID width, $clog2(N), minimum 1
//   FMUL_LAT  fmul core latency, operands stable -> fmul_r valid (>=1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low
//   req_valid  [N]      request i holds an operand pair
//   req_x      [N*12]   operand X of requester i at [12i+11:12i]
//   req_y      [N*12]   operand Y of requester i, same packing
//   req_ready  [N]      one-hot grant (combinational, 0 during reset)
//   fmul_x     [12]     registered operand X to the fmul core
//   fmul_y     [12]     registered operand Y to the fmul core
//   fmul_r     [12]     fmul core result
//   rsp_valid           response valid this cycle
//   rsp_id     [IDW]    owner of rsp_data
//   rsp_data   [12]     registered product
//
// Optional feature, macro FMUL_SCHED_PERF_EN:
//   busy_cnt   [32]     saturating count of cycles with a grant
//   stall_cnt  [32]     saturating count of cycles where a valid requester
//                       was not granted
//
// Latency: grant in cycle t -> rsp_valid in cycle t+2+FMUL_LAT.
// ---------------------------------------------------------------------------
module fmul_rr_scheduler #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int FMUL_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*12-1:0] req_x,
    input  logic [N*12-1:0] req_y,
    output logic [N-1:0]    req_ready,
    output logic [11:0]     fmul_x,
    output logic [11:0]     fmul_y,
    input  logic [11:0]     fmul_r,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic [11:0]     rsp_data
`ifdef FMUL_SCHED_PERF_EN
    ,
    output logic [31:0]     busy_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam logic [IDW:0] N_W = (IDW+1)'(N);

    logic [IDW-1:0] rr_ptr_reg;
    logic [IDW-1:0] rr_ptr_next;
    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   cand;

    logic           issue_vld_reg;
    logic [IDW-1:0] issue_id_reg;

    logic           tag_vld_reg [FMUL_LAT];
    logic [IDW-1:0] tag_id_reg  [FMUL_LAT];

    logic [11:0]    x_arr [N];
    logic [11:0]    y_arr [N];

    // Unpack the flat operand buses so the issue mux is a plain array select.
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign x_arr[gi] = req_x[12*gi +: 12];
        assign y_arr[gi] = req_y[12*gi +: 12];
    end

    // Search upward from rr_ptr, wrapping mod N; the first valid wins.
    // cand is one bit wider than an ID so rr_ptr + k cannot overflow before
    // the wrap correction.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!grant_any && req_valid[cand[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[IDW-1:0];
            end
        end
    end

    // Ready is gated by reset so nothing is accepted while rst_n is low.
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign req_ready[gi] = rst_n & grant_any & (grant_id == IDW'(gi));
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_any) begin
            rr_ptr_next = (grant_id == IDW'(N-1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // Issue stage: operands hold when idle so the core input stays quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            issue_vld_reg <= 1'b0;
            issue_id_reg  <= '0;
            fmul_x        <= '0;
            fmul_y        <= '0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            issue_vld_reg <= grant_any;
            if (grant_any) begin
                issue_id_reg <= grant_id;
                fmul_x       <= x_arr[grant_id];
                fmul_y       <= y_arr[grant_id];
            end
        end
    end

    // Tag pipe: FMUL_LAT stages so the tail lines up with fmul_r.
    for (genvar gi = 0; gi < FMUL_LAT; gi++) begin : g_tag
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tag_vld_reg[gi] <= 1'b0;
                tag_id_reg[gi]  <= '0;
            end else if (gi == 0) begin
                tag_vld_reg[gi] <= issue_vld_reg;
                tag_id_reg[gi]  <= issue_id_reg;
            end else begin
                tag_vld_reg[gi] <= tag_vld_reg[(gi > 0) ? gi-1 : 0];
                tag_id_reg[gi]  <= tag_id_reg[(gi > 0) ? gi-1 : 0];
            end
        end
    end

    // Response register; id/data only load when a tagged result arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tag_vld_reg[FMUL_LAT-1];
            if (tag_vld_reg[FMUL_LAT-1]) begin
                rsp_id   <= tag_id_reg[FMUL_LAT-1];
                rsp_data <= fmul_r;
            end
        end
    end

`ifdef FMUL_SCHED_PERF_EN
    logic stall_evt;
    assign stall_evt = |(req_valid & ~req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (grant_any && (busy_cnt != 32'hFFFF_FFFF)) begin
                busy_cnt <= busy_cnt + 32'd1;
            end
            if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fmul_rr_scheduler
//   Directed, table-driven bench for fmul_rr_scheduler (N=4, FMUL_LAT=1).
//   A behavioural one-cycle fmul core closes the loop. Each step drives the
//   request inputs, checks the combinational grant, and pushes the expected
//   response into a three-deep expectation pipe whose tail is compared with
//   rsp_valid/rsp_id/rsp_data every cycle.
// ---------------------------------------------------------------------------
module tb_fmul_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [47:0] req_x;
    logic [47:0] req_y;
    logic [3:0]  req_ready;
    logic [11:0] fmul_x;
    logic [11:0] fmul_y;
    logic [11:0] fmul_r;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [11:0] rsp_data;
`ifdef FMUL_SCHED_PERF_EN
    logic [31:0] busy_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fmul_rr_scheduler #(.N(4), .IDW(2), .FMUL_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .fmul_x    (fmul_x),
        .fmul_y    (fmul_y),
        .fmul_r    (fmul_r),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef FMUL_SCHED_PERF_EN
        ,
        .busy_cnt  (busy_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Behavioural fmul for normal operands, truncating rounding.
    function automatic logic [11:0] fmul_ref(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] p;
        logic [4:0]  e;
        logic [4:0]  f;
        p = {6'd0, 1'b1, a[4:0]} * {6'd0, 1'b1, b[4:0]};
        e = {1'b0, a[8:5]} + {1'b0, b[8:5]} - 5'd7;
        if (p[11]) begin
            f = p[10:6];
            e = e + 5'd1;
        end else begin
            f = p[9:5];
        end
        return {2'b01, a[9] ^ b[9], e[3:0], f};
    endfunction

    always @(posedge clk) fmul_r <= fmul_ref(fmul_x, fmul_y);

    // Expected-response pipe: [0] loads at the grant edge, [2] is visible
    // on the outputs during the following cycle.
    logic        ev   [3];
    logic [1:0]  eid  [3];
    logic [11:0] edat [3];

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check_rsp(input string tag);
        checks++;
        if (rsp_valid !== ev[2]) begin
            errors++;
            $display("FAIL %s rsp_valid: got %b expected %b", tag, rsp_valid, ev[2]);
        end else if (ev[2]) begin
            checks++;
            if (rsp_id !== eid[2] || rsp_data !== edat[2]) begin
                errors++;
                $display("FAIL %s rsp: got id=%0d data=%h expected id=%0d data=%h",
                         tag, rsp_id, rsp_data, eid[2], edat[2]);
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic [47:0] xs,
                        input logic [47:0] ys, input logic [3:0] er,
                        input logic [11:0] ed, input string tag);
        @(negedge clk);
        check_rsp(tag);
        rst_n     = r;
        req_valid = v;
        req_x     = xs;
        req_y     = ys;
        #1;
        checks++;
        if (req_ready !== er) begin
            errors++;
            $display("FAIL %s req_ready: got %b expected %b", tag, req_ready, er);
        end
        $display("step %-8s rst_n=%b valid=%b ready=%b rsp_valid=%b rsp_id=%0d rsp_data=%h",
                 tag, r, v, req_ready, rsp_valid, rsp_id, rsp_data);
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 3; i++) ev[i] = 1'b0;
        end else begin
            ev[2] = ev[1]; eid[2] = eid[1]; edat[2] = edat[1];
            ev[1] = ev[0]; eid[1] = eid[0]; edat[1] = edat[0];
            ev[0] = |er;   eid[0] = onehot_idx(er); edat[0] = ed;
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [47:0] xs;
        logic [47:0] ys;
        logic [3:0]  exp_ready;
        logic [11:0] exp_data;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] v, input logic [47:0] xs,
                                input logic [47:0] ys, input logic [3:0] er,
                                input logic [11:0] ed, input string tag);
        vec_t t;
        t.rst_n = r; t.valid = v; t.xs = xs; t.ys = ys;
        t.exp_ready = er; t.exp_data = ed; t.tag = tag;
        tbl.push_back(t);
    endfunction

    // Operand sets, requester 3 in the top slice.
    localparam logic [47:0] ONES = {4{12'h4E0}};                             // 1.0 each
    localparam logic [47:0] XD   = {12'h520, 12'h4F0, 12'h500, 12'h4E0};     // 4,1.5,2,1
    localparam logic [47:0] XT   = {12'h4E0, 12'h4E0, 12'h4E0, 12'h4F0};     // req0 1.5
    localparam logic [47:0] YT   = {12'h4E0, 12'h4E0, 12'h4E0, 12'h500};     // req0 2.0

`ifdef FMUL_SCHED_PERF_EN
    logic [31:0] busy0;
    logic [31:0] stall0;
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_x     = ONES;
        req_y     = ONES;
        for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0; eid[i] = 2'd0; edat[i] = 12'h000;
        end

        // Reset held with all requests valid: nothing granted, nothing returned.
        for (int i = 0; i < 3; i++) add(1'b0, 4'hF, ONES, ONES, 4'b0000, 12'h000, "reset");
        // All four valid from rr_ptr=0: strict rotation.
        for (int i = 0; i < 8; i++) add(1'b1, 4'hF, ONES, ONES, 4'b0001 << (i % 4), 12'h4E0, "rotate");
        // Single op 1.5 * 2.0 = 3.0.
        add(1'b1, 4'b0001, XT, YT, 4'b0001, 12'h510, "single");
        for (int i = 0; i < 3; i++) add(1'b1, 4'b0000, ONES, ONES, 4'b0000, 12'h000, "idle");
        // Distinct operands from rr_ptr=1 to exercise the data mux.
        add(1'b1, 4'hF, XD, ONES, 4'b0010, 12'h500, "mux");
        add(1'b1, 4'hF, XD, ONES, 4'b0100, 12'h4F0, "mux");
        add(1'b1, 4'hF, XD, ONES, 4'b1000, 12'h520, "mux");
        add(1'b1, 4'hF, XD, ONES, 4'b0001, 12'h4E0, "mux");
        // Lone requester 2 is granted every cycle.
        for (int i = 0; i < 5; i++) add(1'b1, 4'b0100, XD, ONES, 4'b0100, 12'h4F0, "alone2");
        for (int i = 0; i < 3; i++) add(1'b1, 4'b0000, XD, ONES, 4'b0000, 12'h000, "idle");
        // Grant req1 alone so rr_ptr ends at 2.
        add(1'b1, 4'b0010, XD, ONES, 4'b0010, 12'h500, "setptr");

        foreach (tbl[i]) step(tbl[i].rst_n, tbl[i].valid, tbl[i].xs, tbl[i].ys,
                              tbl[i].exp_ready, tbl[i].exp_data, tbl[i].tag);

        // rr_ptr=2 with req1 and req3: req3 first, then req1 with no bubble.
`ifdef FMUL_SCHED_PERF_EN
        #1;
        busy0  = busy_cnt;
        stall0 = stall_cnt;
`endif
        step(1'b1, 4'b1010, XD, ONES, 4'b1000, 12'h520, "skip");
        step(1'b1, 4'b0010, XD, ONES, 4'b0010, 12'h500, "skip");
`ifdef FMUL_SCHED_PERF_EN
        #1;
        checks++;
        if (busy_cnt !== busy0 + 32'd2 || stall_cnt !== stall0 + 32'd1) begin
            errors++;
            $display("FAIL perf: got busy+%0d stall+%0d expected busy+2 stall+1",
                     busy_cnt - busy0, stall_cnt - stall0);
        end
`endif

        // Two ops in flight, then a one-cycle reset drops both; pointer back to 0.
        step(1'b1, 4'b0001, XD, ONES, 4'b0001, 12'h4E0, "flight");
        step(1'b1, 4'b0010, XD, ONES, 4'b0010, 12'h500, "flight");
        step(1'b0, 4'hF,    XD, ONES, 4'b0000, 12'h000, "midrst");
        step(1'b1, 4'hF,    XD, ONES, 4'b0001, 12'h4E0, "after");
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, XD, ONES, 4'b0000, 12'h000, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
